// File: rtl/move_recorder_pkg.sv
// rtl/move_recorder_pkg.sv - shared puzzle constants: direction codes, move capacity, button indices
package move_recorder_pkg;

   // Default move capacity; ord and cnt are 2*MAX_MOVES bits wide
   localparam int MAX_MOVES = 9;

   // Bit positions within the raw button vector
   localparam int BTN_COMMIT = 4;
   localparam int BTN_UE     = 3;
   localparam int BTN_SHITA  = 2;
   localparam int BTN_HIDARI = 1;
   localparam int BTN_MIGI   = 0;

   // Two-bit move codes packed into ord
   typedef enum logic [1:0] {
      DIR_UE     = 2'd0,
      DIR_SHITA  = 2'd1,
      DIR_HIDARI = 2'd2,
      DIR_MIGI   = 2'd3
   } dir_e;

   // Recorder states
   typedef enum logic {
      ST_REC  = 1'b0,
      ST_DONE = 1'b1
   } state_e;

   // Map the direction part of a one-hot press vector to its move code
   function automatic dir_e btn_to_dir(input logic [3:0] dirs);
      dir_e d;
      if (dirs[BTN_UE])          d = DIR_UE;
      else if (dirs[BTN_SHITA])  d = DIR_SHITA;
      else if (dirs[BTN_HIDARI]) d = DIR_HIDARI;
      else                       d = DIR_MIGI;
      return d;
   endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - prescaled button sampler with per-button press flags and priority select
module btn_edge
   import move_recorder_pkg::*;
#(
   parameter int PRESCALE_W = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] btn,
   output logic [4:0] press
);

   logic [PRESCALE_W-1:0] presc_q;
   logic [4:0]            flag_q;
   logic [4:0]            flag_n;
   logic [4:0]            cand;
   logic                  tick;

   // A sample tick is the single cycle per period where the prescaler wraps to zero
   assign tick = (presc_q == '0);

   // Free-running prescaler
   always_ff @(posedge clk) begin
      if (!rst_n) presc_q <= '0;
      else        presc_q <= presc_q + PRESCALE_W'(1);
   end

   // Choose at most one new press per tick, commit button first, then UE..MIGI
   always_comb begin
      press = '0;
      cand  = btn & ~flag_q & {5{tick}};
      if (cand[BTN_COMMIT])      press[BTN_COMMIT] = 1'b1;
      else if (cand[BTN_UE])     press[BTN_UE]     = 1'b1;
      else if (cand[BTN_SHITA])  press[BTN_SHITA]  = 1'b1;
      else if (cand[BTN_HIDARI]) press[BTN_HIDARI] = 1'b1;
      else if (cand[BTN_MIGI])   press[BTN_MIGI]   = 1'b1;
   end

   // Released buttons drop their flag; only the acted-on press raises one, so losers retry next tick
   always_comb begin
      flag_n = flag_q;
      if (tick) flag_n = (flag_q & btn) | press;
   end

   // Flag register
   always_ff @(posedge clk) begin
      if (!rst_n) flag_q <= '0;
      else        flag_q <= flag_n;
   end

endmodule

// File: rtl/move_recorder.sv
// rtl/move_recorder.sv - records up to MAX_MOVES direction presses and commits them for display
module move_recorder #(
   parameter int PRESCALE_W = 12,
   parameter int MAX_MOVES  = move_recorder_pkg::MAX_MOVES
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [4:0]             btn,
   output logic [2*MAX_MOVES-1:0] ord,
   output logic [2*MAX_MOVES-1:0] cnt,
   output logic                   comp
);
   import move_recorder_pkg::*;

   localparam int W = 2*MAX_MOVES;

   logic [4:0]   press;
   logic [1:0]   code;
   state_e       state_q;
   state_e       state_n;
   logic [W-1:0] ord_q;
   logic [W-1:0] ord_n;
   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_n;

   btn_edge #(
      .PRESCALE_W (PRESCALE_W)
   ) u_btn_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn),
      .press (press)
   );

   assign code = btn_to_dir(press[BTN_UE:BTN_MIGI]);

   // State, move list and count registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_REC;
         ord_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         ord_q   <= ord_n;
         cnt_q   <= cnt_n;
      end
   end

   // Next state: record directions, commit on a non-empty list, clear from DONE
   always_comb begin
      state_n = state_q;
      ord_n   = ord_q;
      cnt_n   = cnt_q;
      case (state_q)
         ST_REC: begin
            if (press[BTN_COMMIT]) begin
               if (cnt_q != '0) state_n = ST_DONE;
            end else if ((|press[BTN_UE:BTN_MIGI]) && (cnt_q < W'(MAX_MOVES))) begin
               for (int k = 0; k < MAX_MOVES; k++) begin
                  if (cnt_q == W'(k)) ord_n[2*k +: 2] = code;
               end
               cnt_n = cnt_q + W'(1);
            end
         end
         ST_DONE: begin
            if (press[BTN_COMMIT]) begin
               ord_n   = '0;
               cnt_n   = '0;
               state_n = ST_REC;
            end
         end
         default: state_n = ST_REC;
      endcase
   end

   assign ord  = ord_q;
   assign cnt  = cnt_q;
   assign comp = (state_q == ST_DONE);

endmodule

// File: tb/tb_move_recorder.sv
// tb/tb_move_recorder.sv - self-checking bench for move_recorder with a tick-level reference model
module tb_move_recorder;

   localparam int PW = 2;
   localparam int MM = 9;
   localparam int PERIOD = 1 << PW;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  btn = '0;
   logic [17:0] ord;
   logic [17:0] cnt;
   logic        comp;

   int tests = 0;
   int fails = 0;

   int         m_moves[$];
   bit         m_done;
   logic [4:0] m_held;

   always #5 clk = ~clk;

   move_recorder #(
      .PRESCALE_W (PW),
      .MAX_MOVES  (MM)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn),
      .ord   (ord),
      .cnt   (cnt),
      .comp  (comp)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_ord();
      logic [31:0] v = 0;
      foreach (m_moves[k]) v = v | (32'(m_moves[k]) << (2*k));
      return v;
   endfunction

   task automatic check_model(input string tag);
      check({tag, "_ord"},  32'(ord),  model_ord());
      check({tag, "_cnt"},  32'(cnt),  32'(m_moves.size()));
      check({tag, "_comp"}, 32'(comp), 32'(m_done));
   endtask

   // A button counts as pressed when it is down now but was not already accepted while held
   task automatic model_tick(input logic [4:0] b);
      int win = -1;
      m_held = m_held & b;
      for (int i = 4; i >= 0; i--) begin
         if (win < 0 && b[i] && !m_held[i]) win = i;
      end
      if (win < 0) return;
      m_held[win] = 1'b1;
      if (win == 4) begin
         if (m_done) begin
            m_moves.delete();
            m_done = 0;
         end else if (m_moves.size() > 0) begin
            m_done = 1;
         end
      end else if (!m_done && m_moves.size() < MM) begin
         m_moves.push_back(3 - win);
      end
   endtask

   // Called in the cycle before a tick edge; leaves the bench in the cycle before the next one
   task automatic tick(input logic [4:0] b, input string tag);
      btn = b;
      @(posedge clk);
      #1;
      model_tick(b);
      check_model(tag);
      repeat (PERIOD - 1) @(posedge clk);
      #1;
      check_model({tag, "_hold"});
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      m_moves.delete();
      m_done = 0;
      m_held = '0;
      check_model("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [4:0] b;

      // Reset then UE, MIGI, HIDARI
      do_reset(2);
      tick(5'b01000, "r28_ue");
      tick(5'b00001, "r28_migi");
      tick(5'b00010, "r28_hidari");
      check("r28_cnt_const", 32'(cnt), 32'd3);
      check("r28_ord_const", 32'(ord), 32'(18'b10_11_00));
      check("r28_comp_const", 32'(comp), 32'd0);

      // Commit with an empty list is swallowed
      do_reset(1);
      tick(5'b10000, "r32_empty_commit");
      check("r32_comp_const", 32'(comp), 32'd0);
      tick(5'b00000, "r32_release");

      // Commit and SHITA rising together with two moves, then SHITA held in DONE
      tick(5'b01000, "r31_m1");
      tick(5'b00001, "r31_m2");
      tick(5'b10100, "r31_both");
      check("r31_comp_const", 32'(comp), 32'd1);
      check("r31_cnt_const", 32'(cnt), 32'd2);
      tick(5'b00100, "r31_shita_held");
      check("r31_cnt_after", 32'(cnt), 32'd2);
      tick(5'b10000, "r32_clear");
      check("r32_ord_clear", 32'(ord), 32'd0);
      check("r32_cnt_clear", 32'(cnt), 32'd0);
      check("r32_comp_clear", 32'(comp), 32'd0);

      // Fill to capacity plus one
      tick(5'b00000, "r29_idle");
      for (int k = 0; k < 10; k++) begin
         b = 5'(1 << (k % 4));
         tick(b, "r29_dir");
      end
      check("r29_cnt_full", 32'(cnt), 32'd9);

      // Held UE is a single move; release and repress adds one more
      do_reset(1);
      for (int k = 0; k < 5; k++) tick(5'b01000, "r30_hold");
      check("r30_cnt_one", 32'(cnt), 32'd1);
      tick(5'b00000, "r30_release");
      tick(5'b01000, "r30_repress");
      check("r30_cnt_two", 32'(cnt), 32'd2);

      // Reset while committed with five moves, button held across release
      for (int k = 0; k < 3; k++) tick(5'(1 << (k % 2)), "r33_fill");
      tick(5'b10000, "r33_commit");
      check("r33_comp_set", 32'(comp), 32'd1);
      check("r33_cnt_five", 32'(cnt), 32'd5);
      btn = 5'b00010;
      do_reset(1);
      tick(5'b00010, "r25_held_across_reset");
      check("r25_cnt_one", 32'(cnt), 32'd1);

      // Random button patterns, commit less frequent, occasional reset
      for (int n = 0; n < 120; n++) begin
         b = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) != 0) b[4] = 1'b0;
         if ($urandom_range(0, 39) == 0) begin
            btn = b;
            do_reset($urandom_range(1, 3));
         end
         tick(b, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule
